// File: rtl/trk_result_axis_tx.sv
// trk_result_axis_tx
// Captures one epoch of tracking-correlator results (E/P/L/Pilot I/Q), sends
// them as a single AXI4-Stream packet (header + results), then pulses
// o_clear_accum so the correlator can start the next epoch.
// Build option: define TRK_TX_TIMESTAMP_EN to append the 64-bit sample
// timestamp (upper word, then lower word) to every packet.
module trk_result_axis_tx #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHANNEL_ID  = 0,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic                    i_enable,
  input  logic                    i_corr_ready,
  input  logic [DATA_WIDTH-1:0]   i_iE,
  input  logic [DATA_WIDTH-1:0]   i_qE,
  input  logic [DATA_WIDTH-1:0]   i_iP,
  input  logic [DATA_WIDTH-1:0]   i_qP,
  input  logic [DATA_WIDTH-1:0]   i_iL,
  input  logic [DATA_WIDTH-1:0]   i_qL,
  input  logic [DATA_WIDTH-1:0]   i_iPilot,
  input  logic [DATA_WIDTH-1:0]   i_qPilot,
  input  logic [2*DATA_WIDTH-1:0] i_sample_count,
  output logic                    o_clear_accum,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [31:0]             o_epoch_count,
  output logic                    o_overrun,
  input  logic                    i_overrun_clr
);

`ifdef TRK_TX_TIMESTAMP_EN
  localparam int NUM_WORDS = 11;
`else
  localparam int NUM_WORDS = 9;
`endif
  localparam int                 IDX_W     = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam int                 STALL_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
  localparam logic [STALL_W-1:0] STALL_PRE = STALL_W'(STALL_LIMIT - 1);
  localparam logic [7:0]         CHAN_TAG  = 8'(CHANNEL_ID);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_CLEAR,
    ST_WAIT_LOW
  } state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [IDX_W-1:0]       idx_next;
  logic [DATA_WIDTH-1:0]  tdata_reg;
  logic                   tvalid_reg;
  logic                   tlast_reg;
  logic                   clear_reg;
  logic [31:0]            epoch_reg;
  logic [STALL_W-1:0]     stall_reg;
  logic                   overrun_reg;

  logic                   capture;
  logic                   stall_hit;
  logic                   overrun_set;
  logic [DATA_WIDTH-1:0]  corr_in  [8];
  logic [DATA_WIDTH-1:0]  word_vec [NUM_WORDS];

  assign capture     = (state_reg == ST_IDLE) && i_enable && i_corr_ready;
  assign stall_hit   = (state_reg == ST_SEND) && !m_axis_tready;
  assign overrun_set = stall_hit && (stall_reg == STALL_PRE);
  assign idx_next    = idx_reg + IDX_W'(1);

  assign corr_in[0] = i_iE;
  assign corr_in[1] = i_qE;
  assign corr_in[2] = i_iP;
  assign corr_in[3] = i_qP;
  assign corr_in[4] = i_iL;
  assign corr_in[5] = i_qL;
  assign corr_in[6] = i_iPilot;
  assign corr_in[7] = i_qPilot;

  // Header carries the epoch count before this packet's increment; the
  // count only moves in ST_CLEAR, so it is stable for the whole packet.
  assign word_vec[0] = DATA_WIDTH'({8'hC5, CHAN_TAG, epoch_reg[15:0]});

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_result
      logic [DATA_WIDTH-1:0] res_reg;

      // Latch this accumulator on the capture cycle; inputs may move during the packet.
      always_ff @(posedge axis_aclk) begin
        if (capture) begin
          res_reg <= corr_in[gi];
        end
      end

      assign word_vec[gi+1] = res_reg;
    end
  endgenerate

`ifdef TRK_TX_TIMESTAMP_EN
  logic [2*DATA_WIDTH-1:0] sample_reg;

  // Latch the sample timestamp together with the accumulators.
  always_ff @(posedge axis_aclk) begin
    if (capture) begin
      sample_reg <= i_sample_count;
    end
  end

  assign word_vec[9]  = sample_reg[2*DATA_WIDTH-1:DATA_WIDTH];
  assign word_vec[10] = sample_reg[DATA_WIDTH-1:0];
`else
  logic unused_sample;
  assign unused_sample = ^i_sample_count;
`endif

  // Packet FSM: capture, stream words, pulse clear, wait for ready to fall.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      clear_reg  <= 1'b0;
      epoch_reg  <= '0;
    end else begin
      clear_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (capture) begin
            idx_reg    <= '0;
            tdata_reg  <= word_vec[0];
            tvalid_reg <= 1'b1;
            tlast_reg  <= 1'b0;
            state_reg  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_axis_tready) begin
            if (tlast_reg) begin
              tvalid_reg <= 1'b0;
              tlast_reg  <= 1'b0;
              clear_reg  <= 1'b1;
              state_reg  <= ST_CLEAR;
            end else begin
              // Next word goes out on the very next cycle: no bubbles.
              idx_reg   <= idx_next;
              tdata_reg <= word_vec[idx_next];
              tlast_reg <= (idx_next == LAST_IDX);
            end
          end
        end
        ST_CLEAR: begin
          epoch_reg <= epoch_reg + 32'd1;
          state_reg <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          // Same epoch must not be captured twice while ready is still held.
          if (!i_corr_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Sink-stall watchdog: counts back-to-back stalled cycles, sets sticky overrun.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      stall_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (stall_hit) begin
        if (stall_reg != STALL_MAX) begin
          stall_reg <= stall_reg + STALL_W'(1);
        end
      end else begin
        stall_reg <= '0;
      end

      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end else if (i_overrun_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign o_clear_accum = clear_reg;
  assign o_epoch_count = epoch_reg;
  assign o_overrun     = overrun_reg;

endmodule

// File: tb/tb_trk_result_axis_tx.sv
// Bench for trk_result_axis_tx: table-driven packets plus hand-written
// stall / reset / enable sequences, with a scoreboard queue of expected words.
module tb_trk_result_axis_tx;

  localparam int LIM = 40;
`ifdef TRK_TX_TIMESTAMP_EN
  localparam int NW = 11;
`else
  localparam int NW = 9;
`endif

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        corr_ready;
  logic [31:0] in_val [8];
  logic [63:0] sample;
  logic        clear_accum;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [31:0] epoch;
  logic        overrun;
  logic        overrun_clr;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  int clr_cnt = 0;
  int tr_mode = 0;
  logic tr_manual = 1'b1;
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  trk_result_axis_tx #(
    .DATA_WIDTH (32),
    .CHANNEL_ID (0),
    .STALL_LIMIT(LIM)
  ) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (aresetn),
    .i_enable      (enable),
    .i_corr_ready  (corr_ready),
    .i_iE          (in_val[0]),
    .i_qE          (in_val[1]),
    .i_iP          (in_val[2]),
    .i_qP          (in_val[3]),
    .i_iL          (in_val[4]),
    .i_qL          (in_val[5]),
    .i_iPilot      (in_val[6]),
    .i_qPilot      (in_val[7]),
    .i_sample_count(sample),
    .o_clear_accum (clear_accum),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .o_epoch_count (epoch),
    .o_overrun     (overrun),
    .i_overrun_clr (overrun_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic logic [31:0] hdr(input int e);
    logic [31:0] ev;
    ev = 32'(e);
    return {8'hC5, 8'h00, ev[15:0]};
  endfunction

  // tready driver; runs 2 time units after the edge so main-thread settings at +1 win
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (tr_mode)
        0: tready = 1'b1;
        1: tready = ~tready;
        2: tready = 1'($urandom_range(0, 1));
        default: tready = tr_manual;
      endcase
    end
  end

  // Stream monitor: scoreboard compare on accept, hold check while stalled
  logic [31:0] held_data;
  logic        held_last;
  logic        held = 1'b0;
  logic        clr_prev = 1'b0;
  logic [32:0] e;
  always @(negedge clk) begin
    if (!aresetn) begin
      held     = 1'b0;
      clr_prev = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 64'(tvalid), 64'(1'b1));
        check("hold_data", 64'(tdata), 64'(held_data));
        check("hold_last", 64'(tlast), 64'(held_last));
      end
      if (clear_accum) begin
        clr_cnt++;
        check("clear_width", 64'(clr_prev), 64'(1'b0));
      end
      clr_prev = clear_accum;
      if (tvalid && tready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got=0x%0h want=none", tdata);
        end else begin
          e = exp_q.pop_front();
          check("word", 64'(tdata), 64'(e[31:0]));
          check("tlast", 64'(tlast), 64'(e[32]));
        end
      end
      held      = tvalid && !tready;
      held_data = tdata;
      held_last = tlast;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic scramble();
    for (int k = 0; k < 8; k++) in_val[k] = 32'hDEAD_0000 ^ $urandom;
    sample = {$urandom, $urandom};
  endtask

  task automatic start_packet(input logic [31:0] base, input logic [63:0] ts, input logic [31:0] h);
    logic last8;
    last8 = (NW == 9);
    for (int k = 0; k < 8; k++) in_val[k] = base + 32'(k);
    sample = ts;
    exp_q.push_back({1'b0, h});
    for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7) && last8, base + 32'(k)});
`ifdef TRK_TX_TIMESTAMP_EN
    exp_q.push_back({1'b0, ts[63:32]});
    exp_q.push_back({1'b1, ts[31:0]});
`endif
    enable     = 1'b1;
    corr_ready = 1'b1;
  endtask

  // Run until the clear pulse is seen; returns number of tvalid cycles seen
  task automatic wait_clear(input int limit, output int vcyc);
    bit ok;
    ok   = 1'b0;
    vcyc = 0;
    for (int c = 0; c < limit && !ok; c++) begin
      @(negedge clk);
      if (tvalid) begin
        vcyc++;
        if (vcyc == 1) scramble();
      end
      if (clear_accum) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL clear_timeout: got=no_clear want=clear within %0d cycles", limit);
    end
  endtask

  task automatic idle_valids(input int n, output int nv);
    nv = 0;
    repeat (n) begin
      @(negedge clk);
      if (tvalid) nv++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_acc(input int target, input string name);
    for (int c = 0; c < 200 && acc_cnt < target; c++) begin
      @(posedge clk);
      #1;
    end
    check(name, 64'(acc_cnt), 64'(target));
  endtask

  typedef struct {
    logic [31:0] base;
    logic [63:0] ts;
    int          mode;
    logic [31:0] exp_hdr;
    logic [31:0] exp_epoch;
  } vec_t;

  vec_t vt [5];
  int   vcyc;
  int   nv;
  int   c0;
  int   a0;
  int   exp_epoch;

  initial begin
    vt[0] = '{32'h0000_0001, 64'h0000_0011_2233_4455, 0, 32'hC500_0000, 32'd1};
    vt[1] = '{32'h1000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 1, 32'hC500_0001, 32'd2};
    vt[2] = '{32'hFFFF_FFF9, 64'h0123_4567_89AB_CDEF, 2, 32'hC500_0002, 32'd3};
    vt[3] = '{32'h8000_0000, 64'hFFFF_FFFF_0000_0001, 0, 32'hC500_0003, 32'd4};
    vt[4] = '{32'h5A5A_0000, 64'h0000_0000_FFFF_FFFF, 1, 32'hC500_0004, 32'd5};

    aresetn     = 1'b0;
    enable      = 1'b0;
    corr_ready  = 1'b0;
    overrun_clr = 1'b0;
    sample      = '0;
    for (int k = 0; k < 8; k++) in_val[k] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 64'(tvalid), 64'(1'b0));
    check("rst_tlast", 64'(tlast), 64'(1'b0));
    check("rst_tdata", 64'(tdata), 64'(32'h0));
    check("rst_clear", 64'(clear_accum), 64'(1'b0));
    check("rst_overrun", 64'(overrun), 64'(1'b0));
    check("rst_epoch", 64'(epoch), 64'(32'h0));
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    // Table: one packet per entry, ready held 20 cycles afterwards
    for (int i = 0; i < 5; i++) begin
      tr_mode = vt[i].mode;
      c0 = clr_cnt;
      start_packet(vt[i].base, vt[i].ts, vt[i].exp_hdr);
      wait_clear(500, vcyc);
      if (vt[i].mode == 0) check("run_len", 64'(vcyc), 64'(NW));
      check("epoch", 64'(epoch), 64'(vt[i].exp_epoch));
      idle_valids(20, nv);
      check("no_recapture", 64'(nv), 64'(0));
      check("clear_pulses", 64'(clr_cnt - c0), 64'(1));
      check("queue_empty", 64'(exp_q.size()), 64'(0));
      corr_ready = 1'b0;
      idle_valids(2, nv);
    end
    exp_epoch = 5;

    // Long stall on W3 -> overrun, packet still completes, clear works
    tr_mode   = 3;
    tr_manual = 1'b1;
    a0 = acc_cnt;
    start_packet(32'h0000_0100, 64'h1, hdr(exp_epoch));
    wait_acc(a0 + 3, "reach_w3");
    tr_manual = 1'b0;
    for (int c = 1; c <= LIM + 5; c++) begin
      @(negedge clk);
      if (c == LIM) check("overrun_pre", 64'(overrun), 64'(1'b0));
      if (c == LIM + 1) check("overrun_set", 64'(overrun), 64'(1'b1));
      @(posedge clk);
      #1;
    end
    check("stall_word", 64'(tdata), 64'(32'h0000_0102));
    tr_manual = 1'b1;
    wait_clear(100, vcyc);
    exp_epoch++;
    check("epoch_t4", 64'(epoch), 64'(exp_epoch));
    check("overrun_sticky", 64'(overrun), 64'(1'b1));
    overrun_clr = 1'b1;
    @(posedge clk);
    #1;
    overrun_clr = 1'b0;
    @(negedge clk);
    check("overrun_clr", 64'(overrun), 64'(1'b0));
    @(posedge clk);
    #1;
    corr_ready = 1'b0;
    idle_valids(2, nv);

    // Reset in the middle of W4
    a0 = acc_cnt;
    c0 = clr_cnt;
    start_packet(32'h0000_0200, 64'h2, hdr(exp_epoch));
    wait_acc(a0 + 4, "reach_w4");
    tr_manual  = 1'b0;
    aresetn    = 1'b0;
    corr_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t5_tvalid", 64'(tvalid), 64'(1'b0));
    check("t5_epoch", 64'(epoch), 64'(32'h0));
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    exp_q.delete();
    idle_valids(5, nv);
    check("t5_no_valid", 64'(nv), 64'(0));
    check("t5_no_clear", 64'(clr_cnt - c0), 64'(0));
    exp_epoch = 0;
    tr_mode = 0;
    start_packet(32'h0000_0300, 64'h3, hdr(exp_epoch));
    wait_clear(100, vcyc);
    exp_epoch++;
    check("t5_epoch_after", 64'(epoch), 64'(exp_epoch));
    check("t5_queue", 64'(exp_q.size()), 64'(0));
    corr_ready = 1'b0;
    idle_valids(2, nv);

    // Enable dropped during W2: packet completes, no further capture
    a0 = acc_cnt;
    c0 = clr_cnt;
    start_packet(32'h0000_0400, 64'h4, hdr(exp_epoch));
    wait_acc(a0 + 2, "reach_w2");
    enable = 1'b0;
    wait_clear(100, vcyc);
    exp_epoch++;
    check("t6_epoch", 64'(epoch), 64'(exp_epoch));
    idle_valids(10, nv);
    corr_ready = 1'b0;
    idle_valids(3, vcyc);
    nv = nv + vcyc;
    corr_ready = 1'b1;
    idle_valids(20, vcyc);
    nv = nv + vcyc;
    check("t6_no_packet", 64'(nv), 64'(0));
    check("t6_clears", 64'(clr_cnt - c0), 64'(1));
    check("t6_queue", 64'(exp_q.size()), 64'(0));
    check("t6_epoch_hold", 64'(epoch), 64'(exp_epoch));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
